// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic blocks.
//   arith_state_e : IDLE / RUN / DONE control states used by the serial units
//   cnt_width()   : bits needed for a counter that must be able to hold `bits`
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arith_state_e;

  function automatic int unsigned cnt_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/restador1bit.sv
// Combinational 1-bit full subtractor: computes a - b - Bin.
//   a, b : operand bits
//   Bin  : borrow in
//   Bout : borrow out
//   d    : difference bit
module restador1bit (
  input  logic a,
  input  logic b,
  input  logic Bin,
  output logic Bout,
  output logic d
);

  assign d    = a ^ b ^ Bin;
  // Borrow when b exceeds a, or when a==b and a borrow is already pending.
  assign Bout = (~a & b) | (~(a ^ b) & Bin);

endmodule

// File: rtl/restador_serial.sv
// Bit-serial unsigned subtractor: Resul = num1 - num2 (mod 2^BITS), LSB first,
// one bit per clock through a single restador1bit cell.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   start      : request, only honoured in IDLE
//   num1, num2 : minuend / subtrahend, captured on the accept edge
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when Resul/Bout carry a fresh result
//   Resul      : difference, held until the next completion
//   Bout       : final borrow, 1 iff num1 < num2
module restador_serial
  import arith_pkg::*;
#(
  parameter int unsigned BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] num1,
  input  logic [BITS-1:0] num2,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] Resul,
  output logic            Bout
);

  localparam int unsigned CW = cnt_width(BITS);

  arith_state_e    r_state;
  logic [BITS-1:0] r_opa;
  logic [BITS-1:0] r_opb;
  // Only the upper BITS-1 partial bits need storing; the newest bit comes
  // straight from the cell on the completion edge.
  logic [BITS-2:0] r_diff;
  logic            r_borrow;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [BITS-1:0] r_resul;
  logic            r_bout;

  logic            w_d;
  logic            w_bnext;
  logic            w_last;
  logic [BITS-1:0] w_diff_next;

  restador1bit u_cell (
    .a    (r_opa[0]),
    .b    (r_opb[0]),
    .Bin  (r_borrow),
    .Bout (w_bnext),
    .d    (w_d)
  );

  assign w_diff_next = {w_d, r_diff};
  assign w_last      = (r_cnt == CW'(BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_resul  <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_opa    <= num1;
            r_opb    <= num2;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_opa    <= r_opa >> 1;
          r_opb    <= r_opb >> 1;
          r_diff   <= w_diff_next[BITS-1:1];
          r_borrow <= w_bnext;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_resul <= w_diff_next;
            r_bout  <= w_bnext;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign Resul = r_resul;
  assign Bout  = r_bout;

endmodule

// File: tb/tb_restador_serial.sv
// Bench for restador_serial: a BITS=4 and a BITS=8 instance checked every
// cycle against a timing/arithmetic model, plus literal expected results.
module tb_restador_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start [2];
  logic [7:0] n1 [2];
  logic [7:0] n2 [2];

  logic       busy4, done4, bo4;
  logic [3:0] res4;
  logic       busy8, done8, bo8;
  logic [7:0] res8;

  logic       o_busy [2];
  logic       o_done [2];
  logic       o_bo [2];
  logic [7:0] o_res [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  restador_serial #(.BITS(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start[0]),
    .num1  (n1[0][3:0]),
    .num2  (n2[0][3:0]),
    .busy  (busy4),
    .done  (done4),
    .Resul (res4),
    .Bout  (bo4)
  );

  restador_serial #(.BITS(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start[1]),
    .num1  (n1[1]),
    .num2  (n2[1]),
    .busy  (busy8),
    .done  (done8),
    .Resul (res8),
    .Bout  (bo8)
  );

  assign o_busy[0] = busy4;
  assign o_done[0] = done4;
  assign o_bo[0]   = bo4;
  assign o_res[0]  = {4'h0, res4};
  assign o_busy[1] = busy8;
  assign o_done[1] = done8;
  assign o_bo[1]   = bo8;
  assign o_res[1]  = res8;

  function automatic int wid(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_cnt counts cycles since acceptance (0 = idle). The result is
  // plain modular subtraction, published BITS edges after acceptance.
  int         m_cnt [2];
  logic [7:0] m_a [2];
  logic [7:0] m_b [2];
  logic [7:0] m_res [2];
  logic       m_bo [2];
  bit         m_on = 1'b0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_a[k]   = '0;
      m_b[k]   = '0;
      m_res[k] = '0;
      m_bo[k]  = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst) m_on <= 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cnt[k] <= 0;
        m_res[k] <= '0;
        m_bo[k]  <= 1'b0;
      end else if (m_cnt[k] == 0) begin
        if (start[k]) begin
          m_a[k]   <= 8'(int'(n1[k]) % (1 << wid(k)));
          m_b[k]   <= 8'(int'(n2[k]) % (1 << wid(k)));
          m_cnt[k] <= 1;
        end
      end else if (m_cnt[k] == wid(k)) begin
        m_res[k] <= 8'((int'(m_a[k]) - int'(m_b[k]) + 256) % (1 << wid(k)));
        m_bo[k]  <= (m_a[k] < m_b[k]);
        m_cnt[k] <= m_cnt[k] + 1;
      end else if (m_cnt[k] == wid(k) + 1) begin
        m_cnt[k] <= 0;
      end else begin
        m_cnt[k] <= m_cnt[k] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d", wid(k)), 32'(o_busy[k]),
            32'(m_cnt[k] >= 1 && m_cnt[k] <= wid(k)));
        chk($sformatf("done%0d", wid(k)), 32'(o_done[k]), 32'(m_cnt[k] == wid(k) + 1));
        chk($sformatf("resul%0d", wid(k)), 32'(o_res[k]), 32'(m_res[k]));
        chk($sformatf("bout%0d", wid(k)), 32'(o_bo[k]), 32'(m_bo[k]));
        chk($sformatf("excl%0d", wid(k)), 32'(o_busy[k] & o_done[k]), 32'd0);
      end
    end
  end

  task automatic run_op(input int k, input int a, input int b, input int exp_r,
                        input int exp_b);
    int n;
    int nb;
    bit seen;
    @(posedge clk);
    #1;
    n1[k] = 8'(a);
    n2[k] = 8'(b);
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    n1[k] = 8'($urandom);
    n2[k] = 8'($urandom);
    n = 0;
    nb = 0;
    seen = 1'b0;
    if (o_busy[k]) nb++;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = o_done[k];
      if (!seen && o_busy[k]) nb++;
    end
    chk($sformatf("lat%0d %0d-%0d", wid(k), a, b), 32'(n), 32'(wid(k)));
    chk($sformatf("busycyc%0d %0d-%0d", wid(k), a, b), 32'(nb), 32'(wid(k)));
    chk($sformatf("res%0d %0d-%0d", wid(k), a, b), 32'(o_res[k]), 32'(exp_r));
    chk($sformatf("bo%0d %0d-%0d", wid(k), a, b), 32'(o_bo[k]), 32'(exp_b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int a;
    int b;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      n1[k] = '0;
      n2[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst busy4", 32'(busy4), 32'd0);
    chk("rst done4", 32'(done4), 32'd0);
    chk("rst res4", 32'(res4), 32'd0);
    chk("rst bo4", 32'(bo4), 32'd0);
    chk("rst res8", 32'(res8), 32'd0);

    run_op(0, 9, 3, 6, 0);
    run_op(0, 3, 9, 'hA, 1);
    run_op(0, 0, 0, 0, 0);
    run_op(0, 'hF, 'hF, 0, 0);
    run_op(0, 0, 1, 'hF, 1);

    // start held high with operands changing every cycle
    @(posedge clk);
    #1;
    start[0] = 1'b1;
    nd = 0;
    repeat (24) begin
      @(posedge clk);
      #1;
      n1[0] = 8'($urandom);
      n2[0] = 8'($urandom);
      if (done4) nd++;
    end
    start[0] = 1'b0;
    chk("stream dones", 32'(nd), 32'd4);

    // reset in the middle of a run aborts it and clears the result
    run_op(0, 9, 3, 6, 0);
    @(posedge clk);
    #1;
    n1[0] = 8'd7;
    n2[0] = 8'd2;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort busy", 32'(busy4), 32'd0);
    chk("abort done", 32'(done4), 32'd0);
    chk("abort res", 32'(res4), 32'd0);
    chk("abort bo", 32'(bo4), 32'd0);
    nd = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done4) nd++;
    end
    chk("abort nodone", 32'(nd), 32'd0);
    run_op(0, 5, 5, 0, 0);

    run_op(1, 200, 55, 145, 0);
    run_op(1, 55, 200, 111, 1);
    repeat (16) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      run_op(1, a, b, (a - b + 256) % 256, (a < b) ? 1 : 0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
